// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the command/snoop bus arbiter.
//   arb_state_t : per-channel arbitration state (IDLE / GRANT / RELEASE)
//   NUM_PROC    : processor-side requesters on the proc channel
//   NUM_SNOOP   : cache-side snoop requesters on the snoop channel
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int NUM_PROC  = 8;
    localparam int NUM_SNOOP = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RELEASE
    } arb_state_t;

endpackage

// File: rtl/arb_grant_fsm.sv
// ---------------------------------------------------------------------------
// arb_grant_fsm
// Grant state machine for one bus channel. The winner is chosen outside;
// this block decides when a new winner may be granted, holds the grant while
// the owner keeps its request high, and inserts one turnaround cycle after
// every release.
//   clk, rst : clock, synchronous active-high reset
//   req      : N level-sensitive requests
//   winner   : index of the requester to grant if arbitration happens now
//   gnt      : registered one-hot-or-zero grant vector
//   fire     : high in the cycle whose edge loads a new grant from winner
// ---------------------------------------------------------------------------
module arb_grant_fsm
    import cache_pkg::*;
#(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [W-1:0] winner,
    output logic [N-1:0] gnt,
    output logic         fire
);

    arb_state_t   state, state_nxt;
    logic [N-1:0] gnt_nxt;
    logic [W-1:0] owner, owner_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            gnt   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        fire      = 1'b0;
        unique case (state)
            // IDLE and RELEASE arbitrate identically; RELEASE only differs in
            // that the bus was released on the previous edge.
            ARB_IDLE, ARB_RELEASE: begin
                if (|req) begin
                    fire      = 1'b1;
                    gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << winner;
                    owner_nxt = winner;
                    state_nxt = ARB_GRANT;
                end else begin
                    gnt_nxt   = '0;
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                // Only the owner's request matters while the bus is held.
                if (!req[owner]) begin
                    gnt_nxt   = '0;
                    state_nxt = ARB_RELEASE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    for (genvar i = 0; i < N; i++) begin : g_chk
        a_rise_needs_req : assert property (@(posedge clk) disable iff (rst)
            $rose(gnt[i]) |-> $past(req[i]));
        a_drop_after_release : assert property (@(posedge clk) disable iff (rst)
            (gnt[i] && !req[i]) |=> !gnt[i]);
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// ---------------------------------------------------------------------------
// com_bus_arbiter
// Arbitrates two independent buses:
//   proc channel  : NUM_PROC cache controllers, round-robin
//   snoop channel : NUM_SNOOP caches plus lower-level memory, fixed priority
//                   (snoop 0 highest, memory lowest) with a starvation
//                   override that lets memory win once it has waited
//                   STARVE_LIMIT cycles.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   Com_Bus_Req_proc  : proc requests        Com_Bus_Gnt_proc  : proc grants
//   Com_Bus_Req_snoop : snoop requests       Com_Bus_Gnt_snoop : snoop grants
//   Mem_snoop_req     : memory snoop request Mem_snoop_gnt     : memory grant
//   Snoop_bus_busy    : any snoop-channel grant active
// ---------------------------------------------------------------------------
module com_bus_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_PROC     = cache_pkg::NUM_PROC,
    parameter int NUM_SNOOP    = cache_pkg::NUM_SNOOP,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
    output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
    input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
    output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
    input  logic                 Mem_snoop_req,
    output logic                 Mem_snoop_gnt,
    output logic                 Snoop_bus_busy
);

    localparam int PW = $clog2(NUM_PROC);
    localparam int SN = NUM_SNOOP + 1;      // memory is the last snoop requester
    localparam int SW = $clog2(SN);

    logic [PW-1:0]    proc_ptr;
    logic [PW-1:0]    proc_winner;
    logic             proc_fire;

    logic [SN-1:0]    snoop_req;
    logic [SN-1:0]    snoop_gnt;
    logic [SW-1:0]    snoop_winner;
    logic             snoop_fire;
    logic [CNT_W-1:0] mem_wait;
    logic             mem_starved;

    // Round-robin: first requester at or after the pointer, wrapping.
    always_comb begin
        int  idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        proc_winner = '0;
        for (int k = 0; k < NUM_PROC; k++) begin
            idx = (int'(proc_ptr) + k) % NUM_PROC;
            if (!found && Com_Bus_Req_proc[idx]) begin
                proc_winner = PW'(idx);
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proc_ptr <= '0;
        end else if (proc_fire) begin
            proc_ptr <= (proc_winner == PW'(NUM_PROC - 1)) ? '0 : proc_winner + 1'b1;
        end
    end

    // Snoop priority; memory is the fallback index and wins outright once
    // starved.
    assign snoop_req   = {Mem_snoop_req, Com_Bus_Req_snoop};
    assign mem_starved = Mem_snoop_req && (mem_wait >= CNT_W'(STARVE_LIMIT));

    always_comb begin
        snoop_winner = SW'(NUM_SNOOP);
        if (!mem_starved) begin
            for (int k = NUM_SNOOP - 1; k >= 0; k--) begin
                if (Com_Bus_Req_snoop[k]) snoop_winner = SW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wait <= '0;
        end else if (!Mem_snoop_req || (snoop_fire && snoop_winner == SW'(NUM_SNOOP))) begin
            mem_wait <= '0;
        end else if (!Mem_snoop_gnt && mem_wait < CNT_W'(STARVE_LIMIT)) begin
            mem_wait <= mem_wait + 1'b1;
        end
    end

    arb_grant_fsm #(.N(NUM_PROC), .W(PW)) u_proc_fsm (
        .clk    (clk),
        .rst    (rst),
        .req    (Com_Bus_Req_proc),
        .winner (proc_winner),
        .gnt    (Com_Bus_Gnt_proc),
        .fire   (proc_fire)
    );

    arb_grant_fsm #(.N(SN), .W(SW)) u_snoop_fsm (
        .clk    (clk),
        .rst    (rst),
        .req    (snoop_req),
        .winner (snoop_winner),
        .gnt    (snoop_gnt),
        .fire   (snoop_fire)
    );

    assign Com_Bus_Gnt_snoop = snoop_gnt[NUM_SNOOP-1:0];
    assign Mem_snoop_gnt     = snoop_gnt[NUM_SNOOP];
    assign Snoop_bus_busy    = |snoop_gnt;

    a_mem_excl : assert property (@(posedge clk) disable iff (rst)
        !(Mem_snoop_gnt && |Com_Bus_Gnt_snoop));

endmodule
